uart_rx_fifo: RTL

Receive-side buffer for the UART link: sits behind `uart_receiver` and turns its per-frame outputs (`Rx_DATA`, `Rx_VALID`, `Rx_PERROR`, `Rx_FERROR`) into a queue of received frames. A host-side reader pops frames through a first-word-fall-through interface. It is the consumer counterpart of the byte writer that feeds `uart_transmitter` through `Tx_DATA`/`Tx_WR`. Overflow is flagged, never silently hidden.

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_fifo_mem.sv | 25 ++
 rtl/uart_rx_fifo.sv | 94 +++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: entry layout and default depth.
package uart_rx_fifo_pkg;

  localparam int ENTRY_W       = 10;
  localparam int FERR_BIT      = 9;
  localparam int PERR_BIT      = 8;
  localparam int DEFAULT_DEPTH = 16;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic       ferr,
                                                    input logic       perr,
                                                    input logic [7:0] data);
    return {ferr, perr, data};
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x ENTRY_W register array: synchronous write, asynchronous (fall-through) read.
module uart_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic               clock,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [ENTRY_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [ENTRY_W-1:0] o_rdata
);

  // Contents are deliberately not reset; validity is tracked by the pointer logic.
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Queues one entry per received UART frame (data plus error flags) for a FWFT host reader.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        Rx_DATA,
  input  logic              Rx_VALID,
  input  logic              Rx_PERROR,
  input  logic              Rx_FERROR,
  input  logic              rd_en,
  input  logic              clr_overrun,
  output logic [7:0]        rd_data,
  output logic              rd_perror,
  output logic              rd_ferror,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic                r_evt_q;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_overrun;

  logic                w_evt;
  logic                w_wr;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_empty;
  logic                w_full;
  logic [ENTRY_W-1:0]  w_wdata;
  logic [ENTRY_W-1:0]  w_rdata;

  // The receiver holds its flags as levels; only the rising edge marks a new frame.
  assign w_evt   = Rx_VALID | Rx_PERROR | Rx_FERROR;
  assign w_wr    = w_evt & ~r_evt_q;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = rd_en & ~w_empty;
  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign w_push  = w_wr & (~w_full | w_pop);
  assign w_drop  = w_wr & w_full & ~rd_en;
  assign w_wdata = pack_entry(Rx_FERROR, Rx_PERROR, Rx_DATA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_evt_q   <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_evt_q <= w_evt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign rd_data   = w_rdata[7:0];
  assign rd_perror = w_rdata[PERR_BIT];
  assign rd_ferror = w_rdata[FERR_BIT];
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overrun   = r_overrun;

endmodule
